output_port_arbiter: RTL and testbench

- Per-output-port packet arbiter for the 5-port mesh router (N, E, W, S, L); one instance per output port.
- Takes the one-hot route requests from the five input-side LBDR units, round-robin grants the output to one input for a whole packet (HEADER through TAIL), and paces flit forwarding with a credit counter mirroring the downstream input FIFO.
- Drives crossbar select and FIFO read enables.

---
 rtl/output_port_arbiter_if.sv | 38 +++
 rtl/output_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_output_port_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/output_port_arbiter_if.sv
// rtl/output_port_arbiter_if.sv - request/flit/credit bundle between input side and one output arbiter
//
// Purpose: groups the arbiter's request-side inputs and its grant/crossbar outputs.
// Signals:
//   req        [NPORTS]    route request from each input's LBDR
//   empty      [NPORTS]    input FIFO empty flags
//   flit_id    [3*NPORTS]  head-flit type of each input FIFO (bit0 HEADER, bit1 PAYLOAD, bit2 TAIL)
//   credit_in              one-cycle pulse, downstream freed a slot
//   grant      [NPORTS]    one-hot owner of this output
//   rd_en      [NPORTS]    one-hot pop of the owner's FIFO
//   xbar_sel   [3]         binary owner index
//   valid_out              a flit crosses the crossbar this cycle
//   credit_cnt [CW]        downstream credits currently available
// Modports: master = input side / environment, slave = arbiter.
interface output_port_arbiter_if #(
    parameter int NPORTS = 5,
    parameter int CW     = 3
);
    logic [NPORTS-1:0]   req;
    logic [NPORTS-1:0]   empty;
    logic [3*NPORTS-1:0] flit_id;
    logic                credit_in;
    logic [NPORTS-1:0]   grant;
    logic [NPORTS-1:0]   rd_en;
    logic [2:0]          xbar_sel;
    logic                valid_out;
    logic [CW-1:0]       credit_cnt;

    modport master (
        output req, empty, flit_id, credit_in,
        input  grant, rd_en, xbar_sel, valid_out, credit_cnt
    );

    modport slave (
        input  req, empty, flit_id, credit_in,
        output grant, rd_en, xbar_sel, valid_out, credit_cnt
    );
endinterface

// File: rtl/output_port_arbiter.sv
// rtl/output_port_arbiter.sv - round-robin packet arbiter with credit pacing for one router output
//
// Purpose: grants this output to one input for a whole packet (HEADER..TAIL), chosen
// round-robin among inputs presenting a HEADER, and forwards flits only while the
// downstream FIFO has credit.
// Ports:
//   clk  router clock
//   rst  synchronous active-low reset
//   bus  output_port_arbiter_if.slave (req/empty/flit_id/credit_in in; grant/rd_en/xbar_sel/valid_out/credit_cnt out)
module output_port_arbiter #(
    parameter int NPORTS     = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int CW         = 3
) (
    input logic                   clk,
    input logic                   rst,
    output_port_arbiter_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CW-1:0] CREDIT_FULL = CW'(FIFO_DEPTH);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_owner;
    logic [2:0]        w_owner_nxt;
    logic [2:0]        r_rr_ptr;
    logic [2:0]        w_rr_nxt;
    logic [CW-1:0]     r_credit;
    logic [CW-1:0]     w_credit_nxt;
    // Set on grant, cleared by the first transfer: the first flit of a packet is
    // the only one allowed to carry the HEADER bit.
    logic              r_first;
    logic              w_first_nxt;

    logic [NPORTS-1:0] w_cand;
    logic              w_found;
    logic [2:0]        w_winner;
    logic [3:0]        w_scan;
    logic [2:0]        w_owner_flit;
    logic              w_owner_empty;
    logic              w_rd;
    logic              w_tail;

    // Arbitration candidates and round-robin winner. The HEADER test looks at
    // bit 0 only so that a single-flit packet (HEADER|TAIL) is also eligible.
    // Scanning from the far end and overwriting leaves the candidate nearest
    // rr_ptr as the winner.
    always_comb begin
        w_cand   = '0;
        w_winner = '0;
        w_scan   = '0;
        for (int i = 0; i < NPORTS; i++) begin
            w_cand[i] = bus.req[i] & ~bus.empty[i] & bus.flit_id[3*i];
        end
        for (int k = NPORTS - 1; k >= 0; k--) begin
            w_scan = {1'b0, r_rr_ptr} + 4'(k);
            if (w_scan >= 4'(NPORTS)) begin
                w_scan = w_scan - 4'(NPORTS);
            end
            if (w_cand[w_scan[2:0]]) begin
                w_winner = w_scan[2:0];
            end
        end
        w_found = |w_cand;
    end

    // Owner's FIFO status and head flit.
    always_comb begin
        w_owner_flit  = '0;
        w_owner_empty = 1'b1;
        for (int i = 0; i < NPORTS; i++) begin
            if (r_owner == 3'(i)) begin
                w_owner_flit  = bus.flit_id[3*i +: 3];
                w_owner_empty = bus.empty[i];
            end
        end
    end

    // Gating on credit here is what keeps the counter from ever underflowing.
    assign w_rd   = (r_state == BUSY) && !w_owner_empty && (r_credit != '0);
    assign w_tail = w_rd && w_owner_flit[2];

    // Next state and outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_rr_nxt     = r_rr_ptr;
        w_first_nxt  = r_first;
        w_credit_nxt = r_credit;
        bus.grant    = '0;
        bus.rd_en    = '0;
        bus.xbar_sel = '0;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = BUSY;
                    w_owner_nxt = w_winner;
                    w_first_nxt = 1'b1;
                end
            end
            BUSY: begin
                bus.xbar_sel = r_owner;
                for (int i = 0; i < NPORTS; i++) begin
                    bus.grant[i] = (r_owner == 3'(i));
                    bus.rd_en[i] = (r_owner == 3'(i)) && w_rd;
                end
                if (w_rd) begin
                    w_first_nxt = 1'b0;
                end
                // rr_ptr moves only when a packet completes.
                if (w_tail) begin
                    w_state_nxt = IDLE;
                    w_rr_nxt    = (r_owner == 3'(NPORTS - 1)) ? 3'd0 : r_owner + 3'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_rd && !bus.credit_in) begin
            w_credit_nxt = r_credit - CW'(1);
        end else if (!w_rd && bus.credit_in && (r_credit != CREDIT_FULL)) begin
            w_credit_nxt = r_credit + CW'(1);
        end
    end

    assign bus.valid_out  = w_rd;
    assign bus.credit_cnt = r_credit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_credit <= CREDIT_FULL;
            r_first  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_credit <= w_credit_nxt;
            r_first  <= w_first_nxt;
        end
    end

    // Protocol checks: a credit returned with no slot outstanding, and a HEADER
    // arriving in the middle of a packet (that flit is still forwarded).
    always_ff @(posedge clk) begin
        if (rst) begin
            a_credit_overflow: assert (!(bus.credit_in && !w_rd && (r_credit == CREDIT_FULL)));
            a_header_midpacket: assert (!(w_rd && w_owner_flit[0] && !r_first));
        end
    end

endmodule

// File: tb/tb_output_port_arbiter.sv
// tb/tb_output_port_arbiter.sv - scoreboard bench for output_port_arbiter
module tb_output_port_arbiter;

    localparam int NP    = 5;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    typedef struct packed {
        logic [2:0] port;
        logic [2:0] ftype;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic edge_rst = 1'b0;

    always #5 clk = ~clk;

    output_port_arbiter_if #(.NPORTS(NP), .CW(CW)) bus ();

    output_port_arbiter #(
        .NPORTS(NP), .FIFO_DEPTH(DEPTH), .CW(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Input-side FIFO contents, pending packet lengths, expected flit stream.
    logic [2:0] fq[NP][$];
    int         plen[NP][$];
    exp_t       sb[$];
    int         gorder[$];

    int vectors     = 0;
    int miscompares = 0;
    int m_credit    = DEPTH;
    int m_rr        = 0;
    int cnt_valid   = 0;
    int popcnt[NP];

    logic [NP-1:0] mid          = '0;
    logic [NP-1:0] stall_mask   = '0;
    logic [NP-1:0] forced_stall = '0;
    logic          stall_rand   = 1'b0;
    logic          auto_credit  = 1'b0;
    logic          force_credit = 1'b0;
    logic [NP-1:0] smp_rd       = '0;
    logic          smp_valid    = 1'b0;
    logic [NP-1:0] prev_grant   = '0;
    logic [NP-1:0] prev_cand    = '0;
    logic          prev_tail    = 1'b0;

    always @(posedge clk) edge_rst <= rst;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int gidx(input logic [NP-1:0] g);
        int r = 0;
        for (int i = 0; i < NP; i++) if (g[i]) r = i;
        return r;
    endfunction

    function automatic logic [2:0] ftype_of(input int len, input int j);
        if (len == 1)            return 3'b101;
        else if (j == 0)         return 3'b001;
        else if (j == len - 1)   return 3'b100;
        else                     return 3'b010;
    endfunction

    function automatic bit fifos_empty();
        for (int i = 0; i < NP; i++) if (fq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < NP; i++) begin
            bus.req[i]           = (fq[i].size() != 0);
            bus.empty[i]         = (fq[i].size() == 0) || stall_mask[i];
            bus.flit_id[3*i +: 3] = (fq[i].size() != 0) ? fq[i][0] : 3'b000;
        end
    endtask

    task automatic add_packet(input int p, input int len);
        for (int j = 0; j < len; j++) fq[p].push_back(ftype_of(len, j));
        plen[p].push_back(len);
    endtask

    // Packet-level reference: all packets of a batch are present at once, so each
    // packet goes to the first port with work at or after the port following the
    // previous owner, and every packet is delivered whole.
    task automatic plan();
        int   p;
        int   len;
        exp_t e;
        bit   more = 1'b1;
        while (more) begin
            p = -1;
            for (int k = 0; k < NP && p < 0; k++) begin
                if (plen[(m_rr + k) % NP].size() != 0) p = (m_rr + k) % NP;
            end
            if (p < 0) begin
                more = 1'b0;
            end else begin
                len = plen[p].pop_front();
                for (int j = 0; j < len; j++) begin
                    e.port  = 3'(p);
                    e.ftype = ftype_of(len, j);
                    sb.push_back(e);
                end
                m_rr = (p + 1) % NP;
            end
        end
    endtask

    task automatic step();
        logic [2:0] f;
        @(posedge clk);
        #1;
        if (!edge_rst) begin
            for (int i = 0; i < NP; i++) begin
                fq[i].delete();
                plen[i].delete();
            end
            sb.delete();
            mid      = '0;
            m_credit = DEPTH;
            m_rr     = 0;
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (smp_rd[i] && fq[i].size() != 0) begin
                    f = fq[i].pop_front();
                    mid[i] = ~f[2];
                    popcnt[i]++;
                end
            end
            m_credit = m_credit + (bus.credit_in ? 1 : 0) - (smp_valid ? 1 : 0);
        end
        bus.credit_in = (force_credit || (auto_credit && $urandom_range(0, 2) == 0)) && (m_credit < DEPTH);
        for (int i = 0; i < NP; i++) begin
            stall_mask[i] = forced_stall[i] || (stall_rand && mid[i] && $urandom_range(0, 3) == 0);
        end
        drive_inputs();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || !fifos_empty()) && n < budget) begin
            step();
            n++;
        end
        if (sb.size() != 0 || !fifos_empty()) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d flits still expected after %0d cycles, expected 0", sb.size(), budget);
        end
        step();
    endtask

    task automatic refill();
        int n = 0;
        force_credit = 1'b1;
        while (m_credit < DEPTH && n < 20) begin
            step();
            n++;
        end
        force_credit = 1'b0;
        step();
    endtask

    task automatic clear_popcnt();
        for (int i = 0; i < NP; i++) popcnt[i] = 0;
    endtask

    // Monitor: checks every cycle at the falling edge and consumes the scoreboard
    // whenever a flit crosses.
    always @(negedge clk) begin
        logic [NP-1:0] g;
        logic [NP-1:0] exp_rd;
        logic [NP-1:0] cand;
        exp_t          e;
        g = bus.grant;
        if (!edge_rst) begin
            check("rst_grant", int'(bus.grant), 0);
            check("rst_rd_en", int'(bus.rd_en), 0);
            check("rst_xbar_sel", int'(bus.xbar_sel), 0);
            check("rst_valid_out", int'(bus.valid_out), 0);
            check("rst_credit_cnt", int'(bus.credit_cnt), DEPTH);
            prev_grant = '0;
            prev_cand  = '0;
            prev_tail  = 1'b0;
            smp_rd     = '0;
            smp_valid  = 1'b0;
        end else begin
            check("grant_onehot0", int'($countones(g) <= 1), 1);
            check("xbar_sel", int'(bus.xbar_sel), gidx(g));
            exp_rd = (m_credit != 0 && (g & ~bus.empty) != '0) ? g : '0;
            check("rd_en", int'(bus.rd_en), int'(exp_rd));
            check("valid_out", int'(bus.valid_out), int'(|bus.rd_en));
            check("credit_cnt", int'(bus.credit_cnt), m_credit);
            if (prev_tail)
                check("idle_gap_grant", int'(g), 0);
            else if (prev_grant != '0)
                check("grant_hold", int'(g), int'(prev_grant));
            else if (prev_cand != '0)
                check("arb_winner", int'(g), (sb.size() != 0) ? (1 << sb[0].port) : 0);
            else
                check("no_req_grant", int'(g), 0);
            if (g != '0 && prev_grant == '0) gorder.push_back(gidx(g));
            prev_tail = 1'b0;
            if (bus.valid_out) begin
                cnt_valid++;
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_flit: flit from port %0d, expected none", bus.xbar_sel);
                end else begin
                    e = sb.pop_front();
                    check("flit_port", int'(bus.xbar_sel), int'(e.port));
                    check("flit_type", (fq[e.port].size() != 0) ? int'(fq[e.port][0]) : 0, int'(e.ftype));
                    prev_tail = e.ftype[2];
                end
            end
            for (int i = 0; i < NP; i++) cand[i] = bus.req[i] & ~bus.empty[i] & bus.flit_id[3*i];
            prev_grant = g;
            prev_cand  = cand;
            smp_rd     = bus.rd_en;
            smp_valid  = bus.valid_out;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        bus.req = '0;
        bus.empty = '1;
        bus.flit_id = '0;
        bus.credit_in = 1'b0;
        clear_popcnt();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();

        // Single 3-flit packet on N, no credit return.
        cnt_valid = 0;
        add_packet(0, 3);
        plan();
        drive_inputs();
        drain(40);
        check("t1_valid_count", cnt_valid, 3);
        check("t1_credit_after", int'(bus.credit_cnt), 1);
        check("t1_grant_idle", int'(bus.grant), 0);

        // Round robin E/L from rr_ptr=0.
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        gorder.delete();
        add_packet(1, 2); add_packet(1, 2);
        add_packet(4, 2); add_packet(4, 2);
        plan();
        drive_inputs();
        auto_credit = 1'b1;
        drain(100);
        check("t2_grant_count", gorder.size(), 4);
        check("t2_order0", (gorder.size() > 0) ? gorder[0] : -1, 1);
        check("t2_order1", (gorder.size() > 1) ? gorder[1] : -1, 4);
        check("t2_order2", (gorder.size() > 2) ? gorder[2] : -1, 1);
        check("t2_order3", (gorder.size() > 3) ? gorder[3] : -1, 4);

        // Credit stall on a 6-flit packet (W).
        auto_credit = 1'b0;
        refill();
        cnt_valid = 0;
        add_packet(2, 6);
        plan();
        drive_inputs();
        repeat (12) step();
        check("t3_stall_count", cnt_valid, 4);
        check("t3_grant_held", int'(bus.grant), 5'b00100);
        check("t3_rd_en_low", int'(bus.rd_en), 0);
        force_credit = 1'b1;
        step();
        force_credit = 1'b0;
        repeat (6) step();
        check("t3_one_more", cnt_valid, 5);
        force_credit = 1'b1;
        step();
        step();
        check("t3_simul_valid", int'(bus.valid_out), 1);
        check("t3_simul_credit_in", int'(bus.credit_in), 1);
        step();
        force_credit = 1'b0;
        check("t3_simul_credit", int'(bus.credit_cnt), 1);
        auto_credit = 1'b1;
        drain(100);

        // Owner FIFO empties after its 2nd flit (S), E waiting.
        refill();
        clear_popcnt();
        add_packet(3, 5);
        add_packet(1, 2);
        plan();
        drive_inputs();
        n = 0;
        while (popcnt[3] < 2 && n < 20) begin
            step();
            n++;
        end
        forced_stall[3] = 1'b1;
        stall_mask[3] = 1'b1;
        drive_inputs();
        repeat (3) begin
            #1;
            check("t4_stall_rd", int'(bus.rd_en), 0);
            check("t4_grant_held", int'(bus.grant), 5'b01000);
            step();
        end
        forced_stall[3] = 1'b0;
        drain(100);
        check("t4_flits_s", popcnt[3], 5);
        check("t4_flits_e", popcnt[1], 2);

        // Single-flit S with W waiting, rr_ptr brought to 3 by a W packet first.
        add_packet(2, 1);
        plan();
        drive_inputs();
        drain(40);
        gorder.delete();
        add_packet(3, 1);
        add_packet(2, 2);
        plan();
        drive_inputs();
        drain(40);
        check("t5_first_s", (gorder.size() > 0) ? gorder[0] : -1, 3);
        check("t5_then_w", (gorder.size() > 1) ? gorder[1] : -1, 2);

        // Reset in the middle of a 4-flit packet.
        refill();
        clear_popcnt();
        add_packet(1, 4);
        plan();
        drive_inputs();
        n = 0;
        while (popcnt[1] < 1 && n < 20) begin
            step();
            n++;
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("t6_grant", int'(bus.grant), 0);
        check("t6_credit", int'(bus.credit_cnt), DEPTH);
        step();
        check("t6_idle_after", int'(bus.grant), 0);

        // Randomised batches with random credit return and owner stalls.
        stall_rand  = 1'b1;
        auto_credit = 1'b1;
        for (int b = 0; b < 25; b++) begin
            for (int p = 0; p < NP; p++) begin
                int npk;
                npk = $urandom_range(0, 2);
                for (int k = 0; k < npk; k++) add_packet(p, $urandom_range(1, 6));
            end
            plan();
            drive_inputs();
            drain(1500);
            if ($urandom_range(0, 4) == 0) begin
                rst = 1'b0;
                step();
                rst = 1'b1;
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
